lift_scan_ctrl: RTL
===================

Name: lift_scan_ctrl

Overview:
Parametrised single-car lift controller. It latches hall-up, hall-down and in-car requests for N_FLOORS floors and serves them with a SCAN (elevator) policy that keeps its current direction while requests remain ahead. It times floor travel and door dwell and drives the car motor and door. It is the successor of the 11-floor lift block and sits under the multi-car dispatcher.

Parameters:
N_FLOORS, 11, number of floors (floor 0 = bottom), min 2
FLOOR_W, $clog2(N_FLOORS), width of floor index
TRAVEL_CYC, 2, clock cycles per floor of travel, >=1
DOOR_CYC, 4, clock cycles door stays open, >=1

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
hall_up_req  in  N_FLOORS  one-cycle or level request, up call at floor i
hall_dn_req  in  N_FLOORS  down call at floor i
car_req  in  N_FLOORS  in-car destination request for floor i
door_hold  in  1  keeps the door open while high in DOOR state
cur_floor  out  FLOOR_W  current floor
motor  out  2  00 stopped, 11 up, 10 down
door_open  out  1  door open
dir_up  out  1  current or last travel direction, 1 = up
pending  out  N_FLOORS  OR of all latched requests per floor

Behaviour:
- Reset values: cur_floor=0, motor=00, door_open=0, dir_up=1, all request registers 0, state IDLE, counters 0. Reset mid-operation aborts immediately to these values.
- Request latching:
  - Inputs are ORed into three registers pend_up, pend_dn and pend_car on each clk edge, with 1-cycle latency.
  - hall_up_req[N_FLOORS-1] and hall_dn_req[0] are ignored and never latched.
  - If a set and a clear hit the same bit in the same cycle, the set wins, except as noted for DOOR.
- Predicates:
  - above = any pending bit at floor > cur_floor.
  - below = any pending bit at floor < cur_floor.
  - here = any pending bit at cur_floor.
- States: IDLE, MOVE, DOOR.
- IDLE:
  - If here, go to DOOR and clear all three bits at cur_floor.
  - Else if above and below, pick the direction given by dir_up.
  - Else if only above, go up (dir_up=1); if only below, go down (dir_up=0).
  - The chosen direction enters MOVE with motor set on that same edge and the travel counter at 0.
  - If no request is pending, stay in IDLE with motor=00.
- MOVE:
  - The travel counter increments each cycle. On the edge where it would reach TRAVEL_CYC, cur_floor steps by ±1 and the counter resets.
  - Stop test on that same edge, for the new floor f:
    - Stop if pend_car[f] is set, or the hall bit in the travel direction at f is set.
    - Also stop if there is no request beyond f in the travel direction and either hall bit at f is set.
  - A stop sets motor=00, door_open=1 and state DOOR on that edge.
  - Served bits cleared on stop: pend_car[f] and the hall bit in the travel direction. The opposite hall bit at f is cleared only if no request remains beyond f; in that case dir_up also flips.
  - cur_floor never leaves the range 0..N_FLOORS-1. Reaching an end floor forces a stop.
- DOOR:
  - The dwell counter counts DOOR_CYC cycles with door_open=1.
  - door_hold=1 reloads the counter to 0.
  - A new request for cur_floor that matches the direction now being served is not latched and reloads the counter.
  - On expiry, door_open=0 on that edge. The next state follows the IDLE decision rules, but current dir_up is preferred: continue if requests remain ahead, reverse if requests remain only behind, otherwise go to IDLE.
- motor=00 whenever door_open=1. This is an invariant for assertions.

Test Plan:
- Basic trip: reset, car_req[3] pulse at cycle 0, TRAVEL_CYC=2, DOOR_CYC=4 -> pending[3]=1 at edge 1; motor=11 at edge 2; cur_floor=1,2,3 at edges 4,6,8; edge 8: motor=00, door_open=1; door closes at edge 12; back to IDLE with pending=0.
- Same-direction pickup: car moving up 0->8 (car_req[8]); hall_up_req[4] while at floor 2; hall_dn_req[5] -> stops at 4, skips 5, stops at 8; then reverses and serves 5 with dir_up=0.
- Direction preference: idle at floor 5 with dir_up=1; car_req[2] and car_req[7] in the same cycle -> serves 7 first, then 2; dir_up=0 after leaving 7.
- Boundary calls: hall_up_req[10] and hall_dn_req[0] with N_FLOORS=11 -> pending stays 0 and motor stays 00.
- Door extension: door_hold high for 3 cycles mid-dwell, then a car_req for cur_floor -> door_open stays 1 until DOOR_CYC cycles after the last reload; the bit is never latched.
- Reset mid-move: rst asserted while motor=11 at floor 3 -> cur_floor=0, motor=00, door_open=0, pending=0 asynchronously.

Source files
------------

// File: rtl/lift_scan_ctrl.sv
// Single-car lift controller: latches hall/car calls and serves them with a SCAN policy,
// timing floor travel and door dwell. Motor and door outputs are registered.
module lift_scan_ctrl #(
    parameter int N_FLOORS   = 11,
    parameter int FLOOR_W    = $clog2(N_FLOORS),
    parameter int TRAVEL_CYC = 2,
    parameter int DOOR_CYC   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_FLOORS-1:0] hall_up_req,
    input  logic [N_FLOORS-1:0] hall_dn_req,
    input  logic [N_FLOORS-1:0] car_req,
    input  logic                door_hold,
    output logic [FLOOR_W-1:0]  cur_floor,
    output logic [1:0]          motor,
    output logic                door_open,
    output logic                dir_up,
    output logic [N_FLOORS-1:0] pending
);

    localparam int TW = (TRAVEL_CYC > 1) ? $clog2(TRAVEL_CYC) : 1;
    localparam int DW = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TRAVEL_CYC - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DOOR_CYC - 1);
    localparam logic [1:0] MOT_STOP = 2'b00;
    localparam logic [1:0] MOT_UP   = 2'b11;
    localparam logic [1:0] MOT_DN   = 2'b10;
    // No up call exists at the top floor and no down call at the bottom floor.
    localparam logic [N_FLOORS-1:0] UP_VALID = {1'b0, {(N_FLOORS-1){1'b1}}};
    localparam logic [N_FLOORS-1:0] DN_VALID = {{(N_FLOORS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

    state_t              state_q, state_d;
    logic [FLOOR_W-1:0]  cur_floor_q, cur_floor_d;
    logic [1:0]          motor_q, motor_d;
    logic                door_open_q, door_open_d;
    logic                dir_up_q, dir_up_d;
    logic [TW-1:0]       trav_q, trav_d;
    logic [DW-1:0]       dwell_q, dwell_d;
    logic [N_FLOORS-1:0] pend_up_q, pend_up_d;
    logic [N_FLOORS-1:0] pend_dn_q, pend_dn_d;
    logic [N_FLOORS-1:0] pend_car_q, pend_car_d;

    logic [N_FLOORS-1:0] pend_any, set_up, set_dn;
    logic [N_FLOORS-1:0] cur_oh, f_oh;
    logic [N_FLOORS-1:0] clr_up, clr_dn, clr_car, blk_up, blk_dn, blk_car;
    logic [FLOOR_W-1:0]  f_new;
    logic                above, below, here, beyond;
    logic                f_car, f_up, f_dn, f_end, stop, go_up, match, ahead, behind;

    always_comb begin
        pend_any = pend_up_q | pend_dn_q | pend_car_q;
        set_up   = hall_up_req & UP_VALID;
        set_dn   = hall_dn_req & DN_VALID;
        f_new    = dir_up_q ? cur_floor_q + FLOOR_W'(1) : cur_floor_q - FLOOR_W'(1);
        above = 1'b0; below = 1'b0; here = 1'b0; beyond = 1'b0;
        cur_oh = '0; f_oh = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (i == int'(cur_floor_q)) begin
                cur_oh[i] = 1'b1;
                here      = here | pend_any[i];
            end
            if (i == int'(f_new)) f_oh[i] = 1'b1;
            if (pend_any[i] && i > int'(cur_floor_q)) above = 1'b1;
            if (pend_any[i] && i < int'(cur_floor_q)) below = 1'b1;
            if (pend_any[i] && (dir_up_q ? (i > int'(f_new)) : (i < int'(f_new)))) beyond = 1'b1;
        end
        f_car  = |(pend_car_q & f_oh);
        f_up   = |(pend_up_q & f_oh);
        f_dn   = |(pend_dn_q & f_oh);
        f_end  = dir_up_q ? (int'(f_new) == N_FLOORS - 1) : (f_new == '0);
        stop   = f_car | (dir_up_q ? f_up : f_dn) | (!beyond & (f_up | f_dn)) | f_end;
        go_up  = (above && below) ? dir_up_q : above;
        match  = |(car_req & cur_oh) | (dir_up_q ? |(set_up & cur_oh) : |(set_dn & cur_oh));
        ahead  = dir_up_q ? above : below;
        behind = dir_up_q ? below : above;

        state_d     = state_q;
        cur_floor_d = cur_floor_q;
        motor_d     = motor_q;
        door_open_d = door_open_q;
        dir_up_d    = dir_up_q;
        trav_d      = trav_q;
        dwell_d     = dwell_q;
        clr_up = '0; clr_dn = '0; clr_car = '0;
        blk_up = '0; blk_dn = '0; blk_car = '0;

        case (state_q)
            S_IDLE: begin
                motor_d = MOT_STOP;
                if (here) begin
                    state_d     = S_DOOR;
                    door_open_d = 1'b1;
                    dwell_d     = '0;
                    clr_up      = cur_oh;
                    clr_dn      = cur_oh;
                    clr_car     = cur_oh;
                end else if (above || below) begin
                    state_d  = S_MOVE;
                    dir_up_d = go_up;
                    motor_d  = go_up ? MOT_UP : MOT_DN;
                    trav_d   = '0;
                end
            end
            S_MOVE: begin
                if (trav_q == T_LAST) begin
                    cur_floor_d = f_new;
                    trav_d      = '0;
                    if (stop) begin
                        state_d     = S_DOOR;
                        motor_d     = MOT_STOP;
                        door_open_d = 1'b1;
                        dwell_d     = '0;
                        clr_car     = f_oh;
                        if (dir_up_q) clr_up = f_oh;
                        else          clr_dn = f_oh;
                        // Nothing left ahead: the opposite call here is served too and we turn round.
                        if (!beyond) begin
                            clr_up   = f_oh;
                            clr_dn   = f_oh;
                            dir_up_d = !dir_up_q;
                        end
                    end
                end else begin
                    trav_d = trav_q + TW'(1);
                end
            end
            S_DOOR: begin
                blk_car = cur_oh;
                if (dir_up_q) blk_up = cur_oh;
                else          blk_dn = cur_oh;
                if (door_hold || match) begin
                    dwell_d = '0;
                end else if (dwell_q == D_LAST) begin
                    door_open_d = 1'b0;
                    if (ahead || behind) begin
                        state_d  = S_MOVE;
                        dir_up_d = ahead ? dir_up_q : !dir_up_q;
                        motor_d  = (ahead ? dir_up_q : !dir_up_q) ? MOT_UP : MOT_DN;
                        trav_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        pend_up_d  = (pend_up_q  & ~clr_up)  | (set_up  & ~blk_up);
        pend_dn_d  = (pend_dn_q  & ~clr_dn)  | (set_dn  & ~blk_dn);
        pend_car_d = (pend_car_q & ~clr_car) | (car_req & ~blk_car);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_floor_q <= '0;
            motor_q     <= MOT_STOP;
            door_open_q <= 1'b0;
            dir_up_q    <= 1'b1;
            trav_q      <= '0;
            dwell_q     <= '0;
            pend_up_q   <= '0;
            pend_dn_q   <= '0;
            pend_car_q  <= '0;
        end else begin
            state_q     <= state_d;
            cur_floor_q <= cur_floor_d;
            motor_q     <= motor_d;
            door_open_q <= door_open_d;
            dir_up_q    <= dir_up_d;
            trav_q      <= trav_d;
            dwell_q     <= dwell_d;
            pend_up_q   <= pend_up_d;
            pend_dn_q   <= pend_dn_d;
            pend_car_q  <= pend_car_d;
        end
    end

    assign cur_floor = cur_floor_q;
    assign motor     = motor_q;
    assign door_open = door_open_q;
    assign dir_up    = dir_up_q;
    assign pending   = pend_any;

endmodule
